// File: rtl/alu_trace_display.sv
// Touch-driven ALU harness: stages operands, sequences one ALU op per exec edge,
// keeps a result history ring and maps it onto LCD slots. Optional: ALU_TRACE_ACCUM_EN.
module alu_trace_display #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 4,
  parameter int HIST_DEPTH = 8,
  parameter int ALU_LAT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        input_sel,
  input  logic              input_valid,
  input  logic [31:0]       input_value,
  input  logic              exec_req,
  input  logic [5:0]        display_number,
  output logic              display_valid,
  output logic [39:0]       display_name,
  output logic [31:0]       display_value,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic [5:0]        hist_count
);

  localparam int          PTR_W   = $clog2(HIST_DEPTH);
  localparam logic [5:0]  DEPTH6  = 6'(HIST_DEPTH);
  localparam logic [3:0]  LAT4    = 4'(ALU_LAT);
  localparam logic [6:0]  HIS_END = 7'(6 + HIST_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT} state_e;

  state_e              state_q;
  logic [3:0]          wait_cnt_q;
  logic                exec_prev_q;
  logic [CTRL_W-1:0]   stg_ctrl_q;
  logic [DATA_W-1:0]   stg_src1_q;
  logic [DATA_W-1:0]   stg_src2_q;
  logic [CTRL_W-1:0]   alu_control_q;
  logic [DATA_W-1:0]   alu_src1_q;
  logic [DATA_W-1:0]   alu_src2_q;
  logic [DATA_W-1:0]   last_q;
  logic [DATA_W-1:0]   ring_q [HIST_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [5:0]          hist_count_q;
  logic                accum_q;
  logic                disp_valid_q;
  logic [39:0]         disp_name_q;
  logic [31:0]         disp_value_q;

  logic                exec_rise;
  logic                capt;
  logic                cmd_clr;
  logic                cmd_tog;

  assign exec_rise = exec_req & ~exec_prev_q;
  assign capt      = (state_q == S_CAPT);
  assign cmd_clr   = input_valid && (input_sel == 2'b01) && (input_value == 32'd0);
`ifdef ALU_TRACE_ACCUM_EN
  assign cmd_tog   = input_valid && (input_sel == 2'b01) && (input_value == 32'd1);
`else
  assign cmd_tog   = 1'b0;
`endif

  // Sequencer: edges arriving outside IDLE are simply lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      exec_prev_q   <= 1'b0;
      alu_control_q <= '0;
      alu_src1_q    <= '0;
      alu_src2_q    <= '0;
    end else begin
      exec_prev_q <= exec_req;
      case (state_q)
        S_IDLE: if (exec_rise) state_q <= S_ISSUE;
        S_ISSUE: begin
          alu_control_q <= stg_ctrl_q;
          alu_src1_q    <= stg_src1_q;
          alu_src2_q    <= stg_src2_q;
          wait_cnt_q    <= '0;
          state_q       <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == LAT4) state_q <= S_CAPT;
          else                    wait_cnt_q <= wait_cnt_q + 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Staging and history. Later assignments take priority: clear beats capture,
  // a touch write to src1 beats the accumulate feedback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_ctrl_q   <= '0;
      stg_src1_q   <= '0;
      stg_src2_q   <= '0;
      last_q       <= '0;
      wr_ptr_q     <= '0;
      hist_count_q <= '0;
      accum_q      <= 1'b0;
      for (int unsigned i = 0; i < HIST_DEPTH; i++) ring_q[i] <= '0;
    end else begin
      if (capt) begin
        last_q <= alu_result;
        if (accum_q) stg_src1_q <= alu_result;
        if (!cmd_clr) begin
          ring_q[wr_ptr_q] <= alu_result;
          wr_ptr_q         <= wr_ptr_q + 1'b1;
          if (hist_count_q != DEPTH6) hist_count_q <= hist_count_q + 6'd1;
        end
      end
      if (cmd_clr) begin
        hist_count_q <= '0;
        wr_ptr_q     <= '0;
        if (!capt) last_q <= '0;
      end
      if (cmd_tog) accum_q <= ~accum_q;
      if (input_valid) begin
        case (input_sel)
          2'b00:   stg_ctrl_q <= input_value[CTRL_W-1:0];
          2'b10:   stg_src1_q <= input_value[DATA_W-1:0];
          2'b11:   stg_src2_q <= input_value[DATA_W-1:0];
          default: ;
        endcase
      end
    end
  end

  logic              disp_valid_d;
  logic [39:0]       disp_name_d;
  logic [31:0]       disp_value_d;
  logic [5:0]        his_k;
  logic [5:0]        his_tens;
  logic [5:0]        his_ones;
  logic [PTR_W-1:0]  his_idx;

  always_comb begin
    disp_valid_d = 1'b0;
    disp_name_d  = '0;
    disp_value_d = '0;
    his_k        = display_number - 6'd6;
    his_tens     = his_k / 6'd10;
    his_ones     = his_k % 6'd10;
    his_idx      = wr_ptr_q - PTR_W'(1) - his_k[PTR_W-1:0];
    case (display_number)
      6'd1: begin disp_valid_d = 1'b1; disp_name_d = "SRC_1"; disp_value_d = 32'(stg_src1_q); end
      6'd2: begin disp_valid_d = 1'b1; disp_name_d = "SRC_2"; disp_value_d = 32'(stg_src2_q); end
      6'd3: begin disp_valid_d = 1'b1; disp_name_d = "CONTR"; disp_value_d = 32'(stg_ctrl_q); end
      6'd4: begin disp_valid_d = 1'b1; disp_name_d = "RESUL"; disp_value_d = 32'(last_q); end
      6'd5: begin
        disp_valid_d = 1'b1;
        disp_name_d  = "COUNT";
        disp_value_d = {accum_q, 25'd0, hist_count_q};
      end
      default: begin
        if (display_number >= 6'd6 && {1'b0, display_number} < HIS_END) begin
          disp_valid_d = (his_k < hist_count_q);
          disp_name_d  = {"HIS", 8'h30 + 8'(his_tens), 8'h30 + 8'(his_ones)};
          disp_value_d = 32'(ring_q[his_idx]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_valid_q <= 1'b0;
      disp_name_q  <= '0;
      disp_value_q <= '0;
    end else begin
      disp_valid_q <= disp_valid_d;
      disp_name_q  <= disp_name_d;
      disp_value_q <= disp_value_d;
    end
  end

  assign display_valid = disp_valid_q;
  assign display_name  = disp_name_q;
  assign display_value = disp_value_q;
  assign alu_control   = alu_control_q;
  assign alu_src1      = alu_src1_q;
  assign alu_src2      = alu_src2_q;
  assign busy          = (state_q != S_IDLE);
  assign hist_count    = hist_count_q;

endmodule

// File: tb/tb_alu_trace_display.sv
// Directed bench for alu_trace_display (ALU_LAT=2, HIST_DEPTH=8) with a small
// combinational ALU: 0 add, 1 sub, 2 and, 3 or.
module tb_alu_trace_display;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  input_sel;
  logic        input_valid;
  logic [31:0] input_value;
  logic        exec_req;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic [3:0]  alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;
  logic        busy;
  logic [5:0]  hist_count;

  int checks = 0;
  int errors = 0;

  alu_trace_display #(
    .DATA_W(32), .CTRL_W(4), .HIST_DEPTH(8), .ALU_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .input_sel(input_sel), .input_valid(input_valid), .input_value(input_value),
    .exec_req(exec_req), .display_number(display_number),
    .display_valid(display_valid), .display_name(display_name), .display_value(display_value),
    .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .busy(busy), .hist_count(hist_count)
  );

  always #50 clk = ~clk;

  always_comb begin
    case (alu_control)
      4'd0:    alu_result = alu_src1 + alu_src2;
      4'd1:    alu_result = alu_src1 - alu_src2;
      4'd2:    alu_result = alu_src1 & alu_src2;
      4'd3:    alu_result = alu_src1 | alu_src2;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic touch(input logic [1:0] sel, input logic [31:0] val);
    input_sel = sel; input_value = val; input_valid = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
  endtask

  // Returns at the negedge right after the edge that samples the rising exec.
  task automatic exec_pulse();
    exec_req = 1'b1;
    @(negedge clk);
    exec_req = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {39'd0, busy}, 40'd0);
  endtask

  task automatic rd(input logic [5:0] slot);
    display_number = slot;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    touch(2'b10, a);
    touch(2'b11, b);
    touch(2'b00, c);
    exec_pulse();
    wait_idle("op_done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] e0, e1, e2, cnt_exp, src1_exp;

    reset = 1'b1; input_sel = '0; input_valid = 1'b0; input_value = '0;
    exec_req = 1'b0; display_number = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", {39'd0, busy}, 40'd0);
    chk("rst_count", 40'(hist_count), 40'd0);
    chk("rst_alu_src1", 40'(alu_src1), 40'd0);
    chk("rst_slot0_valid", {39'd0, display_valid}, 40'd0);
    for (int s = 1; s <= 6; s++) begin
      rd(6'(s));
      chk($sformatf("rst_slot%0d_value", s), 40'(display_value), 40'd0);
    end
    chk("rst_slot6_valid", {39'd0, display_valid}, 40'd0);
    rd(6'd5);
    chk("rst_slot5_name", display_name, "COUNT");
    chk("rst_slot5_valid", {39'd0, display_valid}, 40'd1);

    // Single ADD with latency measurement
    touch(2'b10, 32'd5);
    touch(2'b11, 32'd3);
    touch(2'b00, 32'd0);
    exec_pulse();
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 40'(n), 40'(LAT + 3));
    chk("alu_src1_issued", 40'(alu_src1), 40'd5);
    rd(6'd4);
    chk("add_resul", 40'(display_value), 40'd8);
    rd(6'd6);
    chk("add_his00", 40'(display_value), 40'd8);
    chk("add_his00_valid", {39'd0, display_valid}, 40'd1);
    chk("add_his00_name", display_name, "HIS00");
    rd(6'd5);
    chk("add_count", 40'(display_value), 40'd1);

    // Ten results 1..10 wrap the 8-entry ring
    for (int v = 1; v <= 10; v++) run_op(32'(v), 32'd0, 32'd0);
    chk("wrap_count_port", 40'(hist_count), 40'd8);
    rd(6'd6);
    chk("wrap_his00", 40'(display_value), 40'd10);
    rd(6'd13);
    chk("wrap_his07", 40'(display_value), 40'd3);
    chk("wrap_his07_name", display_name, "HIS07");
    chk("wrap_his07_valid", {39'd0, display_valid}, 40'd1);
    rd(6'd14);
    chk("slot14_valid", {39'd0, display_valid}, 40'd0);
    chk("slot14_value", 40'(display_value), 40'd0);

    // Exec edge and src2 write while busy
    touch(2'b10, 32'd20);
    touch(2'b11, 32'd4);
    touch(2'b00, 32'd1);
    exec_pulse();
    exec_req = 1'b1;
    @(negedge clk);
    exec_req = 1'b0;
    touch(2'b11, 32'd100);
    wait_idle("busy_op_done");
    repeat (4) @(negedge clk);
    chk("no_queued_exec", {39'd0, busy}, 40'd0);
    chk("busy_alu_src2", 40'(alu_src2), 40'd4);
    rd(6'd6);
    chk("busy_his00", 40'(display_value), 40'd16);
    rd(6'd7);
    chk("busy_his01", 40'(display_value), 40'd10);
    rd(6'd2);
    chk("busy_stg_src2", 40'(display_value), 40'd100);

    // Clear command landing on the CAPT cycle
    touch(2'b10, 32'd7);
    touch(2'b11, 32'd2);
    touch(2'b00, 32'd0);
    exec_pulse();
    repeat (LAT + 2) @(negedge clk);
    touch(2'b01, 32'd0);
    wait_idle("clr_op_done");
    chk("clr_count", 40'(hist_count), 40'd0);
    rd(6'd6);
    chk("clr_his00_valid", {39'd0, display_valid}, 40'd0);
    rd(6'd4);
    chk("clr_resul", 40'(display_value), 40'd9);
    run_op(32'd1, 32'd1, 32'd0);
    rd(6'd6);
    chk("post_clr_his00", 40'(display_value), 40'd2);
    chk("post_clr_count", 40'(hist_count), 40'd1);

    // Accumulate chaining (ignored when the option is not built)
    touch(2'b01, 32'd1);
    touch(2'b10, 32'd1);
    touch(2'b11, 32'd1);
    touch(2'b00, 32'd0);
    for (int i = 0; i < 3; i++) begin
      exec_pulse();
      wait_idle("acc_op_done");
    end
`ifdef ALU_TRACE_ACCUM_EN
    e0 = 32'd4; e1 = 32'd3; e2 = 32'd2; cnt_exp = 32'h8000_0004; src1_exp = 32'd4;
`else
    e0 = 32'd2; e1 = 32'd2; e2 = 32'd2; cnt_exp = 32'h0000_0004; src1_exp = 32'd1;
`endif
    rd(6'd6);
    chk("acc_his00", 40'(display_value), 40'(e0));
    rd(6'd7);
    chk("acc_his01", 40'(display_value), 40'(e1));
    rd(6'd8);
    chk("acc_his02", 40'(display_value), 40'(e2));
    rd(6'd5);
    chk("acc_count_slot", 40'(display_value), 40'(cnt_exp));
    rd(6'd1);
    chk("acc_src1", 40'(display_value), 40'(src1_exp));

    // Reset while in WAIT aborts the operation
    exec_pulse();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midwait_reset_busy", {39'd0, busy}, 40'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    chk("midwait_count", 40'(hist_count), 40'd0);
    chk("midwait_busy_after", {39'd0, busy}, 40'd0);
    rd(6'd4);
    chk("midwait_resul", 40'(display_value), 40'd0);
    rd(6'd5);
    chk("midwait_count_slot", 40'(display_value), 40'd0);
    rd(6'd6);
    chk("midwait_his00_valid", {39'd0, display_valid}, 40'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
